counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_pkg.sv | 25 ++
 rtl/counter_core.sv | 38 +++
 rtl/counter_ctrl.sv | 117 +++++++++++
 tb/tb_counter_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter controller: FSM states, command opcodes and
// a saturating increment for the period counter.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OpStart  = 2'd0,
    OpStop   = 2'd1,
    OpPause  = 2'd2,
    OpResume = 2'd3
  } cmd_op_e;

  localparam int unsigned PeriodCntW = 8;

  function automatic logic [PeriodCntW-1:0] sat_inc(input logic [PeriodCntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/counter_core.sv
// Count datapath: counts up while enabled, wraps to zero after the terminal
// value. The wrap flag only reports that the count sits at the terminal.
module counter_core #(
  parameter int unsigned Counter_bit = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [Counter_bit-1:0] terminal,
  output logic [Counter_bit-1:0] count,
  output logic                   wrap
);

  logic [Counter_bit-1:0] count_q, count_d;

  // Ungated by enable so the controller can read it without a comb loop.
  assign wrap  = (count_q == terminal);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven counter controller: valid/ready command interface, a
// four-state run FSM, wrap tick, one-shot done pulse and a period counter.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned Counter_bit      = 4,
  parameter int unsigned Default_terminal = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [Counter_bit-1:0] cmd_term,
  input  logic                   cmd_periodic,
  output logic [Counter_bit-1:0] count,
  output logic                   busy,
  output logic                   tick,
  output logic                   done,
  output logic [7:0]             period_cnt
);

  localparam logic [Counter_bit-1:0] DefTerm = Counter_bit'(Default_terminal);

  state_e                 state_q, state_d;
  logic [Counter_bit-1:0] term_q, term_d;
  logic                   periodic_q, periodic_d;
  logic [PeriodCntW-1:0]  period_q, period_d;
  logic                   tick_q, tick_d;
  logic                   enable, clear, wrap, accept;
  cmd_op_e                op;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q != StDone);
  assign accept    = cmd_valid && cmd_ready;

  // Command priority: START, then STOP/PAUSE, then the wrap itself.
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    periodic_d = periodic_q;
    period_d   = period_q;
    tick_d     = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    if (accept && op == OpStart) begin
      state_d    = StRun;
      term_d     = (cmd_term == '0) ? DefTerm : cmd_term;
      periodic_d = cmd_periodic;
      period_d   = '0;
      clear      = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (accept && op == OpStop) begin
            state_d = StIdle;
            clear   = 1'b1;
          end else if (accept && op == OpPause) begin
            state_d = StPause;
          end else begin
            enable = 1'b1;
            if (wrap) begin
              tick_d   = 1'b1;
              period_d = sat_inc(period_q);
              if (!periodic_q) state_d = StDone;
            end
          end
        end
        StPause: begin
          if (accept && op == OpStop) begin
            state_d = StIdle;
            clear   = 1'b1;
          end else if (accept && op == OpResume) begin
            state_d = StRun;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      term_q     <= DefTerm;
      periodic_q <= 1'b0;
      period_q   <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      periodic_q <= periodic_d;
      period_q   <= period_d;
      tick_q     <= tick_d;
    end
  end

  counter_core #(
    .Counter_bit(Counter_bit)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .terminal (term_q),
    .count    (count),
    .wrap     (wrap)
  );

  assign busy       = (state_q == StRun) || (state_q == StPause);
  assign done       = (state_q == StDone);
  assign tick       = tick_q;
  assign period_cnt = period_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random commands, checked
// against a cycle-level behavioural model of the command rules.
module tb_counter_ctrl;

  localparam int CB = 4;
  localparam int DT = 13;
  localparam int ModeIdle = 0, ModeRun = 1, ModePause = 2, ModeDone = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [CB-1:0] cmd_term = '0;
  logic          cmd_periodic = 1'b0;
  logic          cmd_ready, busy, tick, done;
  logic [CB-1:0] count;
  logic [7:0]    period_cnt;
  logic [15:0]   actv;

  int total = 0;
  int bad   = 0;

  // Model state
  int m_mode, m_count, m_term, m_per;
  bit m_periodic, m_tick;

  counter_ctrl #(
    .Counter_bit      (CB),
    .Default_terminal (DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_term     (cmd_term),
    .cmd_periodic (cmd_periodic),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .period_cnt   (period_cnt)
  );

  always #5 clk = ~clk;

  assign actv = {cmd_ready, busy, tick, done, count, period_cnt};

  function automatic logic [15:0] expv();
    logic [3:0] c;
    logic [7:0] p;
    c = 4'(m_count);
    p = 8'(m_per);
    return {m_mode != ModeDone, (m_mode == ModeRun || m_mode == ModePause), m_tick,
            m_mode == ModeDone, c, p};
  endfunction

  task automatic model_reset();
    m_mode = ModeIdle; m_count = 0; m_term = DT; m_per = 0; m_periodic = 0; m_tick = 0;
  endtask

  // One clock edge of the command rules, using the inputs presented at that edge.
  task automatic model_step();
    bit acc;
    if (!rst) begin
      model_reset();
      return;
    end
    acc    = cmd_valid && (m_mode != ModeDone);
    m_tick = 0;
    if (acc && cmd_op == 2'd0) begin
      m_mode     = ModeRun;
      m_term     = (cmd_term == 0) ? DT : int'(cmd_term);
      m_periodic = cmd_periodic;
      m_count    = 0;
      m_per      = 0;
    end else if (m_mode == ModeDone) begin
      m_mode = ModeIdle;
    end else if (m_mode == ModeRun) begin
      if (acc && cmd_op == 2'd1) begin
        m_mode = ModeIdle; m_count = 0;
      end else if (acc && cmd_op == 2'd2) begin
        m_mode = ModePause;
      end else if (m_count == m_term) begin
        m_count = 0;
        m_tick  = 1;
        m_per   = (m_per < 255) ? m_per + 1 : 255;
        if (!m_periodic) m_mode = ModeDone;
      end else begin
        m_count = m_count + 1;
      end
    end else if (m_mode == ModePause) begin
      if (acc && cmd_op == 2'd1) begin
        m_mode = ModeIdle; m_count = 0;
      end else if (acc && cmd_op == 2'd3) begin
        m_mode = ModeRun;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [1:0] op, input int term, input bit per);
    cmd_valid = 1'b1; cmd_op = op; cmd_term = CB'(term); cmd_periodic = per;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (actv !== expv()) begin
      bad++; $display("FAIL reset_initial act=%h exp=%h", actv, expv());
    end
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_term = 4'd3; cmd_periodic = 1'b1;
    repeat (2) begin
      cyc();
      total++;
      if (actv !== 16'h8000) begin
        bad++; $display("FAIL reset_held act=%h exp=%h", actv, 16'h8000);
      end
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_oneshot();
    int ticks = 0, dones = 0;
    send(2'd0, 5, 1'b0);
    total++;
    if (actv !== expv()) begin
      bad++; $display("FAIL oneshot_start act=%h exp=%h", actv, expv());
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      ticks += int'(tick);
      dones += int'(done);
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL oneshot_cyc%0d act=%h exp=%h", i, actv, expv());
      end
    end
    total++;
    if (ticks != 1 || dones != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL oneshot_pulses ticks=%0d dones=%0d busy=%b exp 1 1 0", ticks, dones, busy);
    end
  endtask

  task automatic test_periodic_default();
    int ticks = 0;
    send(2'd0, 0, 1'b1);
    for (int i = 0; i < 42; i++) begin
      cyc();
      ticks += int'(tick);
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL periodic_cyc%0d act=%h exp=%h", i, actv, expv());
      end
    end
    total++;
    if (period_cnt !== 8'd3 || ticks != 3) begin
      bad++; $display("FAIL periodic_count period_cnt=%0d ticks=%0d exp 3 3", period_cnt, ticks);
    end
    send(2'd1, 0, 1'b0);
    total++;
    if (actv !== expv() || period_cnt !== 8'd3) begin
      bad++; $display("FAIL periodic_stop act=%h exp=%h", actv, expv());
    end
  endtask

  task automatic test_pause();
    int guard = 0, ticks = 0;
    send(2'd0, 9, 1'b0);
    while (count !== 4'd4 && guard < 20) begin
      cyc(); guard++;
    end
    if (guard >= 20) begin
      total++; bad++; $display("FAIL pause_wait timeout count=%0d exp 4", count);
    end
    send(2'd2, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      total++;
      if (actv !== expv() || count !== 4'd4) begin
        bad++; $display("FAIL pause_hold%0d act=%h exp=%h", i, actv, expv());
      end
    end
    send(2'd3, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL pause_resume%0d act=%h exp=%h", i, actv, expv());
      end
      cyc();
      ticks += int'(tick);
    end
    total++;
    if (ticks != 1) begin
      bad++; $display("FAIL pause_wrap ticks=%0d exp 1", ticks);
    end
  endtask

  task automatic test_stop_on_term();
    int term, guard = 0;
    term = int'($urandom_range(1, 15));
    send(2'd0, term, 1'b1);
    while (int'(count) != term && guard < 20) begin
      cyc(); guard++;
    end
    if (guard >= 20) begin
      total++; bad++; $display("FAIL stop_wait timeout count=%0d exp %0d", count, term);
    end
    send(2'd1, 0, 1'b0);
    total++;
    if (actv !== expv() || tick !== 1'b0 || count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL stop_on_term act=%h exp=%h", actv, expv());
    end
  endtask

  task automatic test_start_on_term();
    int guard = 0;
    send(2'd0, 3, 1'b1);
    while (count !== 4'd3 && guard < 20) begin
      cyc(); guard++;
    end
    if (guard >= 20) begin
      total++; bad++; $display("FAIL start_wait timeout count=%0d exp 3", count);
    end
    send(2'd0, 2, 1'b0);
    total++;
    if (actv !== expv() || tick !== 1'b0 || count !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL start_on_term act=%h exp=%h", actv, expv());
    end
    repeat (5) cyc();
  endtask

  task automatic test_saturate();
    send(2'd0, 1, 1'b1);
    for (int i = 0; i < 600; i++) begin
      cyc();
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL saturate_cyc%0d act=%h exp=%h", i, actv, expv());
      end
    end
    total++;
    if (period_cnt !== 8'd255) begin
      bad++; $display("FAIL saturate_final period_cnt=%0d exp 255", period_cnt);
    end
    send(2'd1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int guard = 0, dones = 0;
    send(2'd0, 12, 1'b0);
    while (count !== 4'd7 && guard < 20) begin
      cyc(); guard++;
    end
    if (guard >= 20) begin
      total++; bad++; $display("FAIL rstmid_wait timeout count=%0d exp 7", count);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (actv !== 16'h8000 || actv !== expv()) begin
      bad++; $display("FAIL reset_mid act=%h exp=%h", actv, 16'h8000);
    end
    cyc();
    total++;
    if (actv !== 16'h8000) begin
      bad++; $display("FAIL reset_mid_hold act=%h exp=%h", actv, 16'h8000);
    end
    rst = 1'b1;
    send(2'd0, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL rstmid_restart%0d act=%h exp=%h", i, actv, expv());
      end
      cyc();
      dones += int'(done);
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL rstmid_done dones=%0d exp 1", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cmd_valid    = ($urandom_range(0, 3) == 0);
      cmd_op       = 2'($urandom_range(0, 3));
      cmd_term     = CB'($urandom_range(0, 15));
      cmd_periodic = 1'($urandom_range(0, 1));
      cyc();
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL random_cyc%0d act=%h exp=%h", i, actv, expv());
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_default();
    test_pause();
    test_stop_on_term();
    test_start_on_term();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
